// File: rtl/serial_data_port_pkg.sv
// rtl/serial_data_port_pkg.sv - shared states, op constants and beat counts for serial_data_port
package serial_data_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sdp_state_e;

    localparam bit OP_BYTE = 1'b0;
    localparam bit OP_WORD = 1'b1;

    localparam int SDP_REG_BITS   = 8;
    localparam int SDP_NSHIFT     = 2;
    localparam int SDP_BYTE_BEATS = SDP_REG_BITS / SDP_NSHIFT;
    localparam int SDP_WORD_BEATS = (2 * SDP_REG_BITS) / SDP_NSHIFT;

    function automatic int sdp_beats(input int reg_bits, input int nshift, input bit pair);
        return pair ? (2 * reg_bits) / nshift : reg_bits / nshift;
    endfunction

endpackage

// File: rtl/serial_data_port_shift_reg.sv
// rtl/serial_data_port_shift_reg.sv - sdp_shift_reg: NSHIFT-wide right shift register with load
module sdp_shift_reg #(
    parameter int WIDTH  = 16,
    parameter int NSHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              shift_en,
    input  logic [NSHIFT-1:0] serial_in,
    output logic [NSHIFT-1:0] serial_out,
    output logic [WIDTH-1:0]  q
);

    // New chunks enter at the top so the first chunk ends up at the bottom.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {serial_in, q[WIDTH-1:NSHIFT]};
        end
    end

    assign serial_out = q[NSHIFT-1:0];

endmodule

// File: rtl/serial_data_port.sv
// rtl/serial_data_port.sv - serialised operand/result port to a bit-serial ALU; option SERIAL_DATA_PORT_SYNC_CHECK_EN
module serial_data_port
    import serial_data_port_pkg::*;
#(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*REG_BITS-1:0] in_data,
    input  logic                  in_pair,
    output logic                  op_valid,
    input  logic                  active,
    output logic [NSHIFT-1:0]     data_in2,
    input  logic [NSHIFT-1:0]     data_out,
    input  logic                  op_done,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [2*REG_BITS-1:0] result_data,
    output logic                  sync_err
);

    localparam int DW     = 2 * REG_BITS;
    localparam int WORD_N = sdp_beats(REG_BITS, NSHIFT, OP_WORD);
    localparam int BYTE_N = sdp_beats(REG_BITS, NSHIFT, OP_BYTE);
    localparam int CW     = (WORD_N > 1) ? $clog2(WORD_N) : 1;

    sdp_state_e    state, state_nxt;
    logic          pair_q;
    logic [CW-1:0] cnt;
    logic          accept, beat, last_beat;
    logic [DW-1:0] opnd_load, res_q, unused_opnd_q;
    logic [NSHIFT-1:0] unused_res_out;

    assign accept    = in_valid && in_ready;
    assign beat      = (state == SHIFT) && active;
    assign last_beat = beat && (cnt == CW'(pair_q ? WORD_N - 1 : BYTE_N - 1));
    assign opnd_load = in_pair ? in_data : {{REG_BITS{1'b0}}, in_data[REG_BITS-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        op_valid     = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                op_valid = 1'b1;
                if (last_beat) state_nxt = HOLD;
            end
            HOLD: begin
                result_valid = 1'b1;
                in_ready     = result_ready;
                if (result_ready) state_nxt = in_valid ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_q <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            pair_q <= in_pair;
            cnt    <= '0;
        end else if (beat) begin
            cnt <= cnt + CW'(1);
        end
    end

    sdp_shift_reg #(.WIDTH(DW), .NSHIFT(NSHIFT)) u_opnd (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_data  (opnd_load),
        .shift_en   (beat),
        .serial_in  ({NSHIFT{1'b0}}),
        .serial_out (data_in2),
        .q          (unused_opnd_q)
    );

    sdp_shift_reg #(.WIDTH(DW), .NSHIFT(NSHIFT)) u_res (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_data  ({DW{1'b0}}),
        .shift_en   (beat),
        .serial_in  (data_out),
        .serial_out (unused_res_out),
        .q          (res_q)
    );

    // A byte op only fills the upper half of the result register; realign it to the bottom.
    assign result_data = pair_q ? res_q : {{REG_BITS{1'b0}}, res_q[DW-1:REG_BITS]};

`ifdef SERIAL_DATA_PORT_SYNC_CHECK_EN
    logic sync_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err_q <= 1'b0;
        end else if (beat && (op_done != last_beat)) begin
            sync_err_q <= 1'b1;
        end
    end

    assign sync_err = sync_err_q;
`else
    logic unused_op_done;
    assign unused_op_done = op_done;
    assign sync_err       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_data_port.sv
// tb/tb_serial_data_port.sv - scoreboard bench for serial_data_port
module tb_serial_data_port;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_pair = 1'b0, active = 1'b0, op_done = 1'b0, result_ready = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready, op_valid, result_valid, sync_err;
    logic [1:0]  data_in2, data_out;
    logic [15:0] result_data;
    logic        inv_mode = 1'b0, inject = 1'b0;
    int          total = 0, bad = 0;
    logic [1:0]  beat_q[$];
    logic [15:0] res_q[$];

`ifdef SERIAL_DATA_PORT_SYNC_CHECK_EN
    localparam logic EXP_SYNC = 1'b1;
`else
    localparam logic EXP_SYNC = 1'b0;
`endif

    serial_data_port #(.REG_BITS(8), .NSHIFT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_pair      (in_pair),
        .op_valid     (op_valid),
        .active       (active),
        .data_in2     (data_in2),
        .data_out     (data_out),
        .op_done      (op_done),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    // ALU model: echo or invert the operand chunk
    assign data_out = inv_mode ? ~data_in2 : data_in2;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d, input logic p);
        logic [15:0] m;
        int n;
        m = p ? d : (d & 16'h00FF);
        n = p ? 8 : 4;
        for (int i = 0; i < n; i++) beat_q.push_back(2'(m >> (2 * i)));
        res_q.push_back(inv_mode ? (p ? ~m : (~m & 16'h00FF)) : m);
    endtask

    task automatic start_op(input logic [15:0] d, input logic p);
        push_exp(d, p);
        in_data  = d;
        in_pair  = p;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) tick;
        if (!in_ready) check_val("ready_timeout", 0, 1);
        tick;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_pair  = 1'($urandom);
    endtask

    task automatic wait_valid;
        for (int k = 0; k < 200 && !result_valid; k++) tick;
        if (!result_valid) check_val("result_timeout", 0, 1);
    endtask

    task automatic finish_op(input int dly);
        wait_valid();
        repeat (dly) tick;
        check_val("hold_valid", result_valid, 1);
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
    endtask

    // Scoreboard monitor; also plays the ALU's op_done for the beat about to happen
    always @(negedge clk) begin
        if (reset) begin
            op_done = 1'b0;
        end else begin
            if (op_valid && active) begin
                if (beat_q.size() == 0) check_val("beat_extra", 1, 0);
                else check_val("beat", data_in2, beat_q.pop_front());
            end
            if (result_valid && result_ready) begin
                if (res_q.size() == 0) check_val("result_extra", 1, 0);
                else check_val("result", result_data, res_q.pop_front());
            end
            op_done = op_valid && active && (beat_q.size() == (inject ? 5 : 0));
        end
    end

    initial begin
        int cyc;
        logic [1:0] held;

        repeat (2) tick;
        check_val("rst_op_valid", op_valid, 0);
        check_val("rst_data_in2", data_in2, 0);
        reset = 1'b0;
        tick;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_result_valid", result_valid, 0);
        check_val("rst_result_data", result_data, 0);
        check_val("rst_sync_err", sync_err, 0);

        active = 1'b1;
        start_op(16'h00A5, 1'b0);
        cyc = 2;
        while (!result_valid && cyc < 50) begin
            tick;
            cyc++;
        end
        check_val("lat_byte", cyc, 6);
        finish_op(0);

        inv_mode = 1'b1;
        start_op(16'h1234, 1'b1);
        finish_op(2);

        inv_mode = 1'b0;
        start_op(16'h733C, 1'b0);
        tick;
        cyc = 3;
        active = 1'b0;
        held = data_in2;
        repeat (3) begin
            tick;
            cyc++;
            check_val("stall_hold", data_in2, held);
        end
        active = 1'b1;
        while (!result_valid && cyc < 50) begin
            tick;
            cyc++;
        end
        check_val("lat_stall", cyc, 9);
        finish_op(0);

        inv_mode = 1'b1;
        start_op(16'h005A, 1'b0);
        wait_valid();
        push_exp(16'h00FF, 1'b0);
        in_data      = 16'h00FF;
        in_pair      = 1'b0;
        in_valid     = 1'b1;
        result_ready = 1'b1;
        #1;
        check_val("b2b_ready", in_ready, 1);
        tick;
        in_valid     = 1'b0;
        result_ready = 1'b0;
        check_val("b2b_shift", op_valid, 1);
        check_val("b2b_no_hold", result_valid, 0);
        finish_op(1);

        inv_mode = 1'b0;
        start_op(16'hBEEF, 1'b1);
        repeat (4) tick;
        reset = 1'b1;
        beat_q.delete();
        res_q.delete();
        #1;
        check_val("abort_op_valid", op_valid, 0);
        check_val("abort_result_valid", result_valid, 0);
        check_val("abort_data_in2", data_in2, 0);
        tick;
        reset = 1'b0;
        tick;
        check_val("abort_idle", in_ready, 1);
        check_val("abort_result_data", result_data, 0);

        for (int r = 0; r < 6; r++) begin
            inv_mode = 1'($urandom);
            start_op(16'($urandom), 1'($urandom));
            finish_op(int'($urandom_range(0, 3)));
            check_val("sync_clean", sync_err, 0);
        end

        inject = 1'b1;
        start_op(16'h1234, 1'b1);
        finish_op(0);
        inject = 1'b0;
        check_val("sync_set", sync_err, EXP_SYNC);
        for (int r = 0; r < 2; r++) begin
            start_op(16'h0F0F, 1'(r));
            finish_op(0);
            check_val("sync_sticky", sync_err, EXP_SYNC);
        end

        check_val("beats_left", beat_q.size(), 0);
        check_val("results_left", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
